// File: rtl/and15_serial_pkg.sv
// Shared definitions for the serial ALU blocks: datapath width, counter width, FSM encodings.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
`ifndef AND15_SERIAL_PKG_SV
`define AND15_SERIAL_PKG_SV
package and15_serial_pkg;

  localparam int DATA_W = 15;
  localparam int CNT_W  = 4;

  // Index of the last bit processed in SHIFT; reaching it ends the operation.
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage
`endif

// File: rtl/and15_serial_and1.sv
// Single-bit And gate used as the per-bit operator of the serial ALU.
// Latency: combinational.
// Backpressure: none.
module and15_serial_and1 (
  input  logic x,
  input  logic y,
  output logic z
);

  assign z = x & y;

endmodule

// File: rtl/and15_serial.sv
// Bit-serial 15-bit bitwise And, LSB first, one bit per clock through a single 1-bit And.
// Latency: out_valid rises 15 clocks after the accept edge.
// Backpressure: result held in DONE until out_ready; in_ready low while SHIFT/DONE.
module and15_serial
  import and15_serial_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out,
  output logic              busy
);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   opa;
  logic [DATA_W-1:0]   opb;
  logic [DATA_W-1:0]   res;
  logic                bit_and;

  // The only arithmetic in the block: the current LSBs of the operand shifters.
  and15_serial_and1 u_and1 (
    .x (opa[0]),
    .y (opb[0]),
    .z (bit_and)
  );

  // Control FSM plus the operand/result shifters and bit counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      opa   <= '0;
      opb   <= '0;
      res   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opa   <= a;
            opb   <= b;
            cnt   <= '0;
            res   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          // New bit enters at the top so after 15 shifts bit 0 lands at res[0].
          res <= {bit_and, res[DATA_W-1:1]};
          opa <= opa >> 1;
          opb <= opb >> 1;
          // Counter stops at the last index rather than wrapping.
          if (cnt == LAST_BIT) begin
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Handshake and status flags are pure decodes of the state register.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out       = res;

endmodule
